// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and helpers for the writeback arbiter
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NUM_WB_PORTS = 3;

  localparam int PORT_ALU = 0;
  localparam int PORT_LSU = 1;
  localparam int PORT_MDU = 2;

  typedef logic [1:0] port_idx_t;

  // Round-robin successor over the three writeback ports.
  function automatic port_idx_t rr_next(input port_idx_t p);
    return (p == port_idx_t'(NUM_WB_PORTS - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - requester ports and writeback bus of the arbiter
interface wb_arbiter_if #(
  parameter int XLEN = wb_pkg::XLEN_DEFAULT
);

  logic            p0_valid_i, p1_valid_i, p2_valid_i;
  logic [4:0]      p0_rd_i, p1_rd_i, p2_rd_i;
  logic [XLEN-1:0] p0_data_i, p1_data_i, p2_data_i;
  logic            p0_ready_o, p1_ready_o, p2_ready_o;
  logic            wb_o;
  logic [4:0]      wb_r_o;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output p0_valid_i, p1_valid_i, p2_valid_i,
    output p0_rd_i, p1_rd_i, p2_rd_i,
    output p0_data_i, p1_data_i, p2_data_i,
    input  p0_ready_o, p1_ready_o, p2_ready_o,
    input  wb_o, wb_r_o, result_o, busy_o
  );

  modport slave (
    input  p0_valid_i, p1_valid_i, p2_valid_i,
    input  p0_rd_i, p1_rd_i, p2_rd_i,
    input  p0_data_i, p1_data_i, p2_data_i,
    output p0_ready_o, p1_ready_o, p2_ready_o,
    output wb_o, wb_r_o, result_o, busy_o
  );

endinterface

// File: rtl/wb_port_buf.sv
// rtl/wb_port_buf.sv - one-entry result buffer for a single writeback requester
module wb_port_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  output logic            ready,
  input  logic            grant,
  output logic            buf_valid,
  output logic [4:0]      buf_rd,
  output logic [XLEN-1:0] buf_data
);

  // A granted entry leaves at this edge, so the slot may refill at the same edge.
  assign ready = !buf_valid || grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (in_valid && ready) begin
      buf_valid <= 1'b1;
      buf_rd    <= in_rd;
      buf_data  <= in_data;
    end else if (grant) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter over three buffered result ports
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int        XLEN    = XLEN_DEFAULT,
  parameter port_idx_t RR_INIT = 2'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  logic [NUM_WB_PORTS-1:0] in_valid, ready, buf_valid, grant;
  logic [4:0]              in_rd    [NUM_WB_PORTS];
  logic [XLEN-1:0]         in_data  [NUM_WB_PORTS];
  logic [4:0]              buf_rd   [NUM_WB_PORTS];
  logic [XLEN-1:0]         buf_data [NUM_WB_PORTS];

  port_idx_t       last, gnt_idx, idx;
  logic            gnt_any;
  logic            wb_q;
  logic [4:0]      wb_r_q;
  logic [XLEN-1:0] result_q;

  assign in_valid = {bus.p2_valid_i, bus.p1_valid_i, bus.p0_valid_i};
  assign in_rd[PORT_ALU]   = bus.p0_rd_i;
  assign in_rd[PORT_LSU]   = bus.p1_rd_i;
  assign in_rd[PORT_MDU]   = bus.p2_rd_i;
  assign in_data[PORT_ALU] = bus.p0_data_i;
  assign in_data[PORT_LSU] = bus.p1_data_i;
  assign in_data[PORT_MDU] = bus.p2_data_i;

  for (genvar g = 0; g < NUM_WB_PORTS; g++) begin : g_buf
    wb_port_buf #(.XLEN(XLEN)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_rd     (in_rd[g]),
      .in_data   (in_data[g]),
      .ready     (ready[g]),
      .grant     (grant[g]),
      .buf_valid (buf_valid[g]),
      .buf_rd    (buf_rd[g]),
      .buf_data  (buf_data[g])
    );
  end

  // Search buffered entries only, starting one past the last winner.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = last;
    idx     = rr_next(last);
    for (int k = 0; k < NUM_WB_PORTS; k++) begin
      if (!gnt_any && buf_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
      idx = rr_next(idx);
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= RR_INIT;
      wb_q     <= 1'b0;
      wb_r_q   <= '0;
      result_q <= '0;
    end else begin
      wb_q <= gnt_any;
      if (gnt_any) begin
        last     <= gnt_idx;
        wb_r_q   <= buf_rd[gnt_idx];
        result_q <= buf_data[gnt_idx];
      end
    end
  end

  assign bus.p0_ready_o = ready[PORT_ALU];
  assign bus.p1_ready_o = ready[PORT_LSU];
  assign bus.p2_ready_o = ready[PORT_MDU];
  assign bus.wb_o       = wb_q;
  assign bus.wb_r_o     = wb_r_q;
  assign bus.result_o   = result_q;
  assign bus.busy_o     = (|buf_valid) || wb_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed checks of wb_arbiter against a reference model
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-port single slot, pointer to last winner, registered writeback.
  bit          mv   [3];
  logic [4:0]  mrd  [3];
  logic [31:0] mdat [3];
  int          mlast;
  bit          mwb;
  logic [4:0]  mwr;
  logic [31:0] mres;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= 3; k++) begin
      if (mv[(mlast + k) % 3]) return (mlast + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mv[i] = 0;
    mlast = 2;
    mwb   = 0;
    mwr   = '0;
    mres  = '0;
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    bus.p0_valid_i = v[0]; bus.p1_valid_i = v[1]; bus.p2_valid_i = v[2];
    bus.p0_rd_i    = r0;   bus.p1_rd_i    = r1;   bus.p2_rd_i    = r2;
    bus.p0_data_i  = d0;   bus.p1_data_i  = d1;   bus.p2_data_i  = d2;
  endtask

  task automatic idle();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One clock: compare against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    int          g;
    bit          rdy [3];
    bit          v   [3];
    logic [4:0]  r   [3];
    logic [31:0] d   [3];
    @(negedge clk);
    g = model_grant();
    v[0] = bus.p0_valid_i; v[1] = bus.p1_valid_i; v[2] = bus.p2_valid_i;
    r[0] = bus.p0_rd_i;    r[1] = bus.p1_rd_i;    r[2] = bus.p2_rd_i;
    d[0] = bus.p0_data_i;  d[1] = bus.p1_data_i;  d[2] = bus.p2_data_i;
    for (int i = 0; i < 3; i++) rdy[i] = !mv[i] || (g == i);
    check("p0_ready", bus.p0_ready_o, rdy[0]);
    check("p1_ready", bus.p1_ready_o, rdy[1]);
    check("p2_ready", bus.p2_ready_o, rdy[2]);
    check("wb", bus.wb_o, mwb);
    check("wb_r", bus.wb_r_o, mwr);
    check("result", bus.result_o, mres);
    check("busy", bus.busy_o, mv[0] || mv[1] || mv[2] || mwb);
    @(posedge clk);
    if (rst_n) begin
      mwb = (g >= 0);
      if (g >= 0) begin
        mwr   = mrd[g];
        mres  = mdat[g];
        mlast = g;
        mv[g] = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && rdy[i]) begin
          mv[i]   = 1;
          mrd[i]  = r[i];
          mdat[i] = d[i];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] prev_r;
    bit         prev_wb;
    int         s0, s2;

    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb", bus.wb_o, 1'b0);
    check("rst_wb_r", bus.wb_r_o, 5'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_ready", {bus.p2_ready_o, bus.p1_ready_o, bus.p0_ready_o}, 3'b111);
    rst_n = 1'b1;

    // Single uncontended p0 transfer: visible two cycles after acceptance, for one cycle.
    drive(3'b001, 5'd5, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0);
    step();
    idle();
    check("lat_early_wb", bus.wb_o, 1'b0);
    step();
    check("lat_wb", bus.wb_o, 1'b1);
    check("lat_wb_r", bus.wb_r_o, 5'd5);
    check("lat_result", bus.result_o, 32'h1234);
    step();
    check("lat_one_cycle", bus.wb_o, 1'b0);

    // All three at once from reset pointer: order rd 1, 2, 3.
    do_reset();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    check("all_ready", {bus.p2_ready_o, bus.p1_ready_o, bus.p0_ready_o}, 3'b111);
    step();
    idle();
    step();
    check("order_1", bus.wb_r_o, 5'd1);
    check("order_1_data", bus.result_o, 32'hA);
    step();
    check("order_2", bus.wb_r_o, 5'd2);
    step();
    check("order_3", bus.wb_r_o, 5'd3);
    check("order_3_wb", bus.wb_o, 1'b1);
    step();

    // p1 with rd=0 is written back unfiltered.
    drive(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
    step();
    idle();
    step();
    check("rd0_wb", bus.wb_o, 1'b1);
    check("rd0_wb_r", bus.wb_r_o, 5'd0);
    check("rd0_result", bus.result_o, 32'hFFFF_FFFF);
    step();

    // p0 and p2 streaming every cycle must alternate with at most one stalled cycle each.
    do_reset();
    prev_wb = 0; prev_r = '0; s0 = 0; s2 = 0;
    for (int i = 0; i < 16; i++) begin
      drive(3'b101, 5'd10, 5'd0, 5'd12, 32'(i), 32'd0, 32'(100 + i));
      s0 = bus.p0_ready_o ? 0 : s0 + 1;
      s2 = bus.p2_ready_o ? 0 : s2 + 1;
      check("p0_stall_max1", s0 <= 1, 1'b1);
      check("p2_stall_max1", s2 <= 1, 1'b1);
      step();
      if (bus.wb_o && prev_wb) check("alternate", bus.wb_r_o, (prev_r == 5'd10) ? 5'd12 : 5'd10);
      prev_wb = bus.wb_o;
      prev_r  = bus.wb_r_o;
    end
    idle();
    repeat (4) step();

    // Reset with all buffers full drops everything; p0 wins first afterwards.
    do_reset();
    drive(3'b111, 5'd7, 5'd8, 5'd9, 32'h70, 32'h80, 32'h90);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb", bus.wb_o, 1'b0);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_ready", {bus.p2_ready_o, bus.p1_ready_o, bus.p0_ready_o}, 3'b111);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    check("no_stale_wb", bus.wb_o, 1'b0);
    drive(3'b111, 5'd21, 5'd22, 5'd23, 32'h21, 32'h22, 32'h23);
    step();
    idle();
    step();
    check("post_rst_first", bus.wb_r_o, 5'd21);
    repeat (3) step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom);
      step();
    end
    idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
